// File: rtl/gs_hp_spec_if.sv
// Fetch/execute port bundle for the gshare branch predictor.
// The master drives fetch and resolve inputs; the slave (predictor) drives the prediction.
interface gs_hp_spec_if #(
  parameter int W = 32
);
  logic [W-1:0] in_fetch_pc;
  logic         in_fetch_nop;
  logic [W-1:0] in_exe_pc;
  logic         in_exe_nop;
  logic         in_exe_branch_taken;
  logic [W-1:0] in_exe_branch_offset;
  logic         in_exe_mispredict;
  logic [W-1:0] out_pc_offset;
  logic         out_fetch_branch_taken;
  logic         out_btb_hit;

  modport master (
    output in_fetch_pc, in_fetch_nop, in_exe_pc, in_exe_nop,
           in_exe_branch_taken, in_exe_branch_offset, in_exe_mispredict,
    input  out_pc_offset, out_fetch_branch_taken, out_btb_hit
  );

  modport slave (
    input  in_fetch_pc, in_fetch_nop, in_exe_pc, in_exe_nop,
           in_exe_branch_taken, in_exe_branch_offset, in_exe_mispredict,
    output out_pc_offset, out_fetch_branch_taken, out_btb_hit
  );
endinterface

// File: rtl/gs_hp_spec.sv
// Gshare branch predictor with a direct-mapped target buffer, a speculative fetch
// history and an architectural history used to repair the fetch history on mispredict.
module gs_hp_spec #(
  parameter int BHT_ENTRIES     = 256,
  parameter int BTB_ENTRIES     = 64,
  parameter int BTB_TAG_BITS    = 8,
  parameter int CTR_BITS        = 2,
  parameter int INSTR_SIZE_BYTE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gs_hp_spec_if.slave bus
);
  localparam int GHR_BITS = $clog2(BHT_ENTRIES);
  localparam int BTB_IDX  = $clog2(BTB_ENTRIES);
  localparam int OB       = $clog2(INSTR_SIZE_BYTE);
  localparam int W        = INSTR_SIZE_BYTE * 8;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0]     ctr       [BHT_ENTRIES];
  logic                    btb_valid [BTB_ENTRIES];
  logic [BTB_TAG_BITS-1:0] btb_tag   [BTB_ENTRIES];
  logic [W-1:0]            btb_off   [BTB_ENTRIES];
  logic [GHR_BITS-1:0]     spec_ghr;
  logic [GHR_BITS-1:0]     arch_ghr;

  logic [GHR_BITS-1:0]     fetch_idx;
  logic [BTB_IDX-1:0]      fetch_bidx;
  logic [BTB_TAG_BITS-1:0] fetch_tag;
  logic [CTR_BITS-1:0]     fetch_ctr;
  logic [GHR_BITS-1:0]     exe_idx;
  logic [BTB_IDX-1:0]      exe_bidx;
  logic [BTB_TAG_BITS-1:0] exe_tag;
  logic [CTR_BITS-1:0]     exe_ctr;
  logic                    exe_valid;
  logic                    exe_taken;
  logic                    fetch_hit;
  logic                    fetch_taken;
  logic                    unused_pc_bits;

  assign fetch_idx  = bus.in_fetch_pc[OB+GHR_BITS-1:OB] ^ spec_ghr;
  assign fetch_bidx = bus.in_fetch_pc[OB+BTB_IDX-1:OB];
  assign fetch_tag  = bus.in_fetch_pc[OB+BTB_IDX+BTB_TAG_BITS-1:OB+BTB_IDX];
  assign fetch_ctr  = ctr[fetch_idx];
  assign exe_idx    = bus.in_exe_pc[OB+GHR_BITS-1:OB] ^ arch_ghr;
  assign exe_bidx   = bus.in_exe_pc[OB+BTB_IDX-1:OB];
  assign exe_tag    = bus.in_exe_pc[OB+BTB_IDX+BTB_TAG_BITS-1:OB+BTB_IDX];
  assign exe_ctr    = ctr[exe_idx];
  assign exe_valid  = !bus.in_exe_nop;
  assign exe_taken  = bus.in_exe_branch_taken;

  assign unused_pc_bits = ^{bus.in_fetch_pc, bus.in_exe_pc};

  // Prediction reads pre-update state, so a same-cycle resolve is only seen next cycle.
  always_comb begin
    fetch_hit   = btb_valid[fetch_bidx] && (btb_tag[fetch_bidx] == fetch_tag) && !bus.in_fetch_nop;
    fetch_taken = fetch_hit && fetch_ctr[CTR_BITS-1];
  end

  assign bus.out_btb_hit            = fetch_hit;
  assign bus.out_fetch_branch_taken = fetch_taken;
  assign bus.out_pc_offset          = fetch_hit ? btb_off[fetch_bidx] : '0;

  // Resolve-side training; a mispredict rebuilds the fetch history from the
  // architectural one and takes precedence over the speculative shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= CTR_INIT;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_tag[i]   <= '0;
        btb_off[i]   <= '0;
      end
    end else begin
      if (exe_valid) begin
        if (exe_taken && exe_ctr != CTR_MAX) ctr[exe_idx] <= exe_ctr + 1'b1;
        else if (!exe_taken && exe_ctr != '0) ctr[exe_idx] <= exe_ctr - 1'b1;
        arch_ghr <= {arch_ghr[GHR_BITS-2:0], exe_taken};
        if (exe_taken) begin
          btb_valid[exe_bidx] <= 1'b1;
          btb_tag[exe_bidx]   <= exe_tag;
          btb_off[exe_bidx]   <= bus.in_exe_branch_offset;
        end
      end
      if (exe_valid && bus.in_exe_mispredict) spec_ghr <= {arch_ghr[GHR_BITS-2:0], exe_taken};
      else if (fetch_hit) spec_ghr <= {spec_ghr[GHR_BITS-2:0], fetch_taken};
    end
  end
endmodule

// File: tb/tb_gs_hp_spec.sv
// Self-checking bench for gs_hp_spec: directed scenarios plus randomized traffic
// compared against a behavioural predictor model built from plain arithmetic.
module tb_gs_hp_spec;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gs_hp_spec_if bus ();
  gs_hp_spec dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  int          m_ctr [256];
  bit          m_v   [64];
  int          m_tag [64];
  logic [31:0] m_off [64];
  int          m_spec, m_arch;
  bit          p_hit, p_taken;
  logic [31:0] p_off;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) m_ctr[i] = 1;
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_off[i] = '0;
    end
    m_spec = 0; m_arch = 0;
  endtask

  task automatic modelPredict(input logic [31:0] fpc, input bit fnop);
    int word, b;
    word = int'(fpc / 4);
    b = word % 64;
    p_hit   = !fnop && m_v[b] && (m_tag[b] == int'((fpc / 256) % 256));
    p_taken = p_hit && (m_ctr[(word % 256) ^ m_spec] >= 2);
    p_off   = p_hit ? m_off[b] : 32'h0;
  endtask

  task automatic modelUpdate(input logic [31:0] epc, input bit enop, input bit et,
                             input logic [31:0] eoff, input bit em);
    int nspec, word, e, b;
    nspec = m_spec;
    if (!enop && em) nspec = ((m_arch * 2) + int'(et)) % 256;
    else if (p_hit) nspec = ((m_spec * 2) + int'(p_taken)) % 256;
    if (!enop) begin
      word = int'(epc / 4);
      e = (word % 256) ^ m_arch;
      b = word % 64;
      if (et && m_ctr[e] < 3) m_ctr[e]++;
      if (!et && m_ctr[e] > 0) m_ctr[e]--;
      m_arch = ((m_arch * 2) + int'(et)) % 256;
      if (et) begin
        m_v[b] = 1; m_tag[b] = int'((epc / 256) % 256); m_off[b] = eoff;
      end
    end
    m_spec = nspec;
  endtask

  // One clocked step: check combinational prediction, clock, then check both histories.
  task automatic applyStimulus(input logic [31:0] fpc, input bit fnop, input logic [31:0] epc,
                               input bit enop, input bit et, input logic [31:0] eoff, input bit em);
    bus.in_fetch_pc = fpc; bus.in_fetch_nop = fnop;
    bus.in_exe_pc = epc; bus.in_exe_nop = enop; bus.in_exe_branch_taken = et;
    bus.in_exe_branch_offset = eoff; bus.in_exe_mispredict = em;
    #1;
    modelPredict(fpc, fnop);
    checkOutput("btb_hit", 32'(bus.out_btb_hit), 32'(p_hit));
    checkOutput("pred_taken", 32'(bus.out_fetch_branch_taken), 32'(p_taken));
    checkOutput("pc_offset", bus.out_pc_offset, p_off);
    @(posedge clk);
    modelUpdate(epc, enop, et, eoff, em);
    #1;
    checkOutput("spec_ghr", 32'(dut.spec_ghr), 32'(m_spec));
    checkOutput("arch_ghr", 32'(dut.arch_ghr), 32'(m_arch));
    @(negedge clk);
  endtask

  task automatic probeFetch(input logic [31:0] fpc);
    bus.in_fetch_pc = fpc; bus.in_fetch_nop = 1'b0; bus.in_exe_nop = 1'b1;
    bus.in_exe_mispredict = 1'b1;
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    probeFetch(32'h100);
    checkOutput("rst_hit", 32'(bus.out_btb_hit), 32'h0);
    checkOutput("rst_taken", 32'(bus.out_fetch_branch_taken), 32'h0);
    checkOutput("rst_offset", bus.out_pc_offset, 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    logic [31:0] pc;
    rst_n = 1'b1;
    bus.in_fetch_pc = '0; bus.in_fetch_nop = 1'b1; bus.in_exe_pc = '0; bus.in_exe_nop = 1'b1;
    bus.in_exe_branch_taken = 1'b0; bus.in_exe_branch_offset = '0; bus.in_exe_mispredict = 1'b0;
    @(negedge clk);
    doReset();
    applyStimulus(32'h100, 0, 32'h0, 1, 0, 32'h0, 0);

    // Train 0x100 twice via recovery, then walk history back to zero with not-taken resolves.
    applyStimulus(32'h0, 1, 32'h100, 0, 1, 32'h20, 1);
    applyStimulus(32'h0, 1, 32'h100, 0, 1, 32'h20, 1);
    for (int i = 0; i < 8; i++) applyStimulus(32'h0, 1, 32'h004, 0, 0, 32'h0, 1);
    probeFetch(32'h100);
    checkOutput("train_hit", 32'(bus.out_btb_hit), 32'h1);
    checkOutput("train_taken", 32'(bus.out_fetch_branch_taken), 32'h1);
    checkOutput("train_offset", bus.out_pc_offset, 32'h20);
    @(negedge clk);

    // Recovery overrides a same-cycle speculative shift.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(32'h0, 1, 32'h100, 0, 1, 32'h40, 0);
    for (int i = 0; i < 5; i++) applyStimulus(32'h100, 0, 32'h0, 1, 0, 32'h0, 0);
    checkOutput("pre_recover_spec", 32'(dut.spec_ghr), 32'h1E);
    applyStimulus(32'h100, 0, 32'h100, 0, 1, 32'h40, 1);
    checkOutput("recover_spec", 32'(dut.spec_ghr), 32'h1F);

    // Counter saturation on one fixed pattern-table entry.
    doReset();
    for (int i = 0; i < 4; i++) begin
      pc = 32'((16 ^ m_arch) * 4);
      applyStimulus(32'h0, 1, pc, 0, 0, 32'h0, 0);
    end
    checkOutput("ctr_floor", 32'(dut.ctr[16]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      pc = 32'((16 ^ m_arch) * 4);
      applyStimulus(32'h0, 1, pc, 0, 1, 32'h8, 0);
    end
    checkOutput("ctr_ceiling", 32'(dut.ctr[16]), 32'h3);

    // BTB alias eviction.
    doReset();
    applyStimulus(32'h0, 1, 32'h100, 0, 1, 32'h11, 0);
    applyStimulus(32'h0, 1, 32'h200, 0, 1, 32'h22, 0);
    probeFetch(32'h100);
    checkOutput("alias_old_hit", 32'(bus.out_btb_hit), 32'h0);
    checkOutput("alias_old_offset", bus.out_pc_offset, 32'h0);
    probeFetch(32'h200);
    checkOutput("alias_new_hit", 32'(bus.out_btb_hit), 32'h1);
    checkOutput("alias_new_offset", bus.out_pc_offset, 32'h22);
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(32'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 256)),
                    ($urandom_range(0, 3) == 0),
                    32'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 256)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges after training.
    applyStimulus(32'h0, 1, 32'h100, 0, 1, 32'h33, 0);
    probeFetch(32'h100);
    checkOutput("pre_async_hit", 32'(bus.out_btb_hit), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_hit", 32'(bus.out_btb_hit), 32'h0);
    checkOutput("async_taken", 32'(bus.out_fetch_branch_taken), 32'h0);
    checkOutput("async_offset", bus.out_pc_offset, 32'h0);
    checkOutput("async_spec", 32'(dut.spec_ghr), 32'h0);
    checkOutput("async_arch", 32'(dut.arch_ghr), 32'h0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut.ctr[i] !== 2'b01) bad++;
    checkOutput("async_ctr_bad", 32'(bad), 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(32'($urandom_range(0, 63) * 4), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 63) * 4), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
